// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4_ctrl slice: op codes, FSM states, response entry.
// Imported by the ALU, the controller and the bench.
package alu4_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    typedef struct packed {
        logic [3:0] result;
        logic       cout;
        logic       zero;
    } rsp_t;

endpackage

// File: rtl/alu4_ctrl_if.sv
// Command/response bundle of alu4_ctrl; master is the command source and result consumer,
// slave is the controller.
interface alu4_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_src;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_cout;
    logic       rsp_zero;
    logic [3:0] acc;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, acc, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, acc, busy
    );
endinterface

// File: rtl/alu_4bit.sv
// 4-bit ripple ALU: ADD, SUB (A + ~B + 1, cout=1 means no borrow), AND, OR.
// Purely combinational; cout is only meaningful for ADD/SUB.
module alu_4bit
    import alu4_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [1:0] i_op,
    output logic [3:0] o_y,
    output logic       o_cout
);

    logic [3:0] w_bx;
    logic [3:0] w_sum;
    logic [4:0] w_c;

    assign w_bx   = (i_op == OP_SUB) ? ~i_b : i_b;
    assign w_c[0] = (i_op == OP_SUB);

    for (genvar g = 0; g < 4; g++) begin : g_bit
        assign w_sum[g]   = i_a[g] ^ w_bx[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & w_bx[g]) | (w_c[g] & (i_a[g] ^ w_bx[g]));
    end

    always_comb begin
        o_y = w_sum;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            default: o_y = w_sum;
        endcase
    end

    assign o_cout = w_c[4];

endmodule

// File: rtl/alu4_ctrl.sv
// Sequencer around alu_4bit: accepts one command per 2 cycles, accumulator write-back, DEPTH-entry response FIFO.
// Response visible 2 cycles after the handshake; cmd_ready drops while the FIFO is full. Optional ALU4_CTRL_SAT_EN saturates.
module alu4_ctrl
    import alu4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu4_ctrl_if.slave  bus
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  L_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]  CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        r_state;
    logic [3:0]    r_a;
    logic [3:0]    r_b;
    logic [1:0]    r_op;
    logic [3:0]    r_acc;
    rsp_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [3:0]    w_y;
    logic          w_cout;
    logic [3:0]    w_res;
    rsp_t          w_entry;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    alu_4bit u_alu (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_op   (r_op),
        .o_y    (w_y),
        .o_cout (w_cout)
    );

    always_comb begin
        w_res = w_y;
`ifdef ALU4_CTRL_SAT_EN
        if (r_op == OP_ADD && w_cout)
            w_res = 4'hF;
        else if (r_op == OP_SUB && !w_cout)
            w_res = 4'h0;
`endif
        w_entry.result = w_res;
        w_entry.cout   = (r_op == OP_AND || r_op == OP_OR) ? 1'b0 : w_cout;
        w_entry.zero   = (w_res == 4'h0);
    end

    assign bus.cmd_ready = (r_state == IDLE) && (r_count < L_FULL);
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_push        = (r_state == EXEC);
    assign w_pop         = bus.rsp_valid && bus.rsp_ready;

    // Operand A is latched at acceptance, so src=1 always sees the previous write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= 4'h0;
            r_b     <= 4'h0;
            r_op    <= OP_ADD;
            r_acc   <= 4'h0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.cmd_src ? r_acc : bus.cmd_a;
                        r_b     <= bus.cmd_b;
                        r_op    <= bus.cmd_op;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_acc   <= w_res;
                    r_wptr  <= r_wptr + PTR_ONE;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wptr] <= w_entry;
    end

    assign bus.rsp_valid  = (r_count != '0);
    assign bus.rsp_result = r_mem[r_rptr].result;
    assign bus.rsp_cout   = r_mem[r_rptr].cout;
    assign bus.rsp_zero   = r_mem[r_rptr].zero;
    assign bus.acc        = r_acc;
    assign bus.busy       = (r_state == EXEC);

endmodule

// File: doc/alu4_ctrl.md
# alu4_ctrl

Sequencing front end for the 4-bit ripple ALU (`alu_4bit`). It accepts operation commands over a valid/ready handshake and drives the ALU's operand and op inputs from registers. It captures each result into a 4-bit accumulator and queues result/flag responses in a small FIFO with downstream backpressure. It sits between a command source (test sequencer or microcontroller stub) and any consumer of ALU results.

## Interface
- `DEPTH`, 4: response FIFO entries, a power of two, minimum 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_op`  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `cmd_src`  in  1  operand A select: 1 selects the accumulator, 0 selects `cmd_a`.
- `cmd_a`  in  4  operand A, used when `cmd_src`=0.
- `cmd_b`  in  4  operand B.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  consumer pops the head when this and `rsp_valid` are both high.
- `rsp_result`  out  4  head result.
- `rsp_cout`  out  1  head carry. For SUB, 1 means no borrow (A≥B).
- `rsp_zero`  out  1  head result == 0.
- `acc`  out  4  accumulator.
- `busy`  out  1  a command is in flight (EXEC state).

## Operation
- FSM states:
  - IDLE: `cmd_ready` = (count < DEPTH). On a handshake, latch A (the accumulator or `cmd_a`, selected by `cmd_src`), B and op into operand registers, then go to EXEC.
  - EXEC: the operand registers drive `alu_4bit`. At the end of the cycle:
    - push {result, cout, zero} into the FIFO;
    - set `acc` to result;
    - return to IDLE.
- `cmd_ready` is low in EXEC. Throughput is one command per 2 cycles.
- An accumulator read with `cmd_src`=1 uses the value from before this command's write-back. Back-to-back chaining is therefore correct.
- Carry handling:
  - ADD uses the ALU cout directly.
  - SUB uses the ALU cout directly; the ALU itself injects cin=1.
  - For AND and OR, the stored cout is forced to 0.
- All arithmetic is modulo 16. `zero` is computed on the value that is stored.
- FIFO behaviour:
  - Circular buffer; the write and read pointers wrap at DEPTH.
  - `count` has range 0..DEPTH.
  - Full means count==DEPTH. Room for the push is guaranteed because acceptance requires count<DEPTH and only one command is ever in flight.
  - A push and a pop in the same cycle leave `count` unchanged.
  - A pop while empty has no effect.
  - When empty, `rsp_result`, `rsp_cout` and `rsp_zero` are undefined.
- Reset values:
  - FSM returns to IDLE; `acc`=0; pointers and count are 0.
  - `rsp_valid`=0, `busy`=0.
  - `cmd_ready`=1 in the first cycle after reset is released.
  - Reset during EXEC drops the in-flight command and flushes the FIFO.

## Timing
- Handshake in cycle N leads to EXEC in cycle N+1.
- The entry and `acc` are written at the end of N+1.
- With an empty FIFO, `rsp_valid` is high in cycle N+2. The next command can be accepted in N+2.
- `rsp_*` outputs come from registers. There is no combinational path from `cmd_*` to `rsp_*`.
- `cmd_ready` depends only on state and count, not on `cmd_valid` or `rsp_ready`.

## Configuration
- `ALU4_CTRL_SAT_EN` defined: saturating arithmetic.
  - ADD with cout=1 stores 4'hF.
  - SUB with cout=0 (borrow) stores 4'h0.
  - The stored cout stays the raw ALU value, `zero` follows the saturated value, and `acc` takes the saturated value.
- `ALU4_CTRL_SAT_EN` undefined: results wrap modulo 16; no saturation logic is present.

## Structure
- Shared package `alu4_pkg` holds:
  - op constants `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_AND`=2'b10, `OP_OR`=2'b11;
  - the FSM state typedef {IDLE, EXEC};
  - the response entry struct {result[3:0], cout, zero}.
- There is one sub-module: the existing `alu_4bit`, instantiated once. The FIFO stays inline.

## Test plan
- Basic ADD: ADD `cmd_a`=5, `cmd_b`=3, src=0. Response 8, cout 0, zero 0 at N+2; `acc`=8.
- SUB with borrow: SUB 3−5. Response 4'hE with cout 0. With `ALU4_CTRL_SAT_EN` defined, response 0 with zero 1.
- Accumulator chaining: ADD 4'hF+1, then ADD src=1 with b=2.
  - First response: 0, cout 1, zero 1 (saturated build: F, cout 1).
  - Second response: 2 (saturated build: F, cout 1, since F+2 carries).
- Backpressure: `rsp_ready`=0, issue 5 ADDs.
  - Exactly DEPTH=4 are accepted, then `cmd_ready` stays 0.
  - Raise `rsp_ready` for one cycle: the pop frees a slot and the fifth command is accepted.
  - Pop order matches issue order.
- Logic ops: AND C&A gives 8 with cout 0. OR 0|0 gives 0 with zero 1.
- Reset mid-operation: assert `rst` during EXEC with 2 entries queued. In the next cycle:
  - `rsp_valid`=0, `acc`=0, `busy`=0;
  - no stale response ever appears.
